// File: rtl/multicycle_control_if.sv
// multicycle_control_if: decoded instruction fields in, datapath enables and mux selects out.
// master is the control FSM side, slave is the datapath side.
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, Illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle RV32I core (lw, sw, R/I ALU, beq/bne, jal).
// Define MULTICYCLE_CTRL_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module multicycle_control (
    input  logic clk,
    input  logic reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    state_t     r_state, w_next, w_dec_next;
    logic       w_mem_ok, w_pcwrite, w_adrsrc, w_memwrite, w_irwrite, w_regwrite, w_illegal;
    logic [1:0] w_resultsrc, w_srca, w_srcb, w_immsrc;
    logic [2:0] w_aluctl, w_alu_dec;
    logic       w_is_sw;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    assign w_mem_ok = bus.mem_ready;
`else
    // memory always completes in one cycle, so mem_ready is a don't-care
    assign w_mem_ok = bus.mem_ready | 1'b1;
`endif

    assign w_is_sw = (bus.op == 7'b0100011);

    assign w_dec_next = (bus.op == 7'b0000011 || w_is_sw) ? S_MEMADR  :
                        (bus.op == 7'b0110011)            ? S_EXECR   :
                        (bus.op == 7'b0010011)            ? S_EXECI   :
                        (bus.op == 7'b1100011)            ? S_BRANCH  :
                        (bus.op == 7'b1101111)            ? S_JAL     : S_FETCH;

    // funct7b5 selects sub only for R-type; addi's imm[10] lands on the same bit
    assign w_alu_dec = (bus.funct3 == 3'b000) ? ((r_state == S_EXECR && bus.funct7b5) ? 3'b001 : 3'b000) :
                       (bus.funct3 == 3'b010) ? 3'b101 :
                       (bus.funct3 == 3'b110) ? 3'b011 :
                       (bus.funct3 == 3'b111) ? 3'b010 : 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pcwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        w_resultsrc = 2'b00;
        w_srca      = 2'b00;
        w_srcb      = 2'b00;
        w_immsrc    = 2'b00;
        w_aluctl    = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = w_mem_ok;
                w_pcwrite   = w_mem_ok;
                w_srcb      = 2'b10;
                w_resultsrc = 2'b10;
                w_next      = w_mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_srca    = 2'b01;
                w_srcb    = 2'b01;
                w_immsrc  = 2'b10;
                w_illegal = (w_dec_next == S_FETCH);
                w_next    = w_dec_next;
            end
            S_MEMADR: begin
                w_srca   = 2'b10;
                w_srcb   = 2'b01;
                w_immsrc = w_is_sw ? 2'b01 : 2'b00;
                w_next   = w_is_sw ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = w_mem_ok ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_next     = w_mem_ok ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_srca   = 2'b10;
                w_aluctl = w_alu_dec;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                w_srca   = 2'b10;
                w_srcb   = 2'b01;
                w_aluctl = w_alu_dec;
                w_next   = S_ALUWB;
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_BRANCH: begin
                w_srca    = 2'b10;
                w_aluctl  = 3'b001;
                w_pcwrite = bus.zero ^ bus.funct3[0];
            end
            S_JAL: begin
                w_srca    = 2'b01;
                w_srcb    = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // write enables are gated so nothing commits while reset is held
    assign bus.PCWrite    = w_pcwrite & ~reset;
    assign bus.MemWrite   = w_memwrite & ~reset;
    assign bus.IRWrite    = w_irwrite & ~reset;
    assign bus.RegWrite   = w_regwrite & ~reset;
    assign bus.Illegal    = w_illegal & ~reset;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_srca;
    assign bus.ALUSrcB    = w_srcb;
    assign bus.ImmSrc     = w_immsrc;
    assign bus.ALUControl = w_aluctl;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction expected control-word queues built from the instruction's cycle recipe.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    multicycle_control_if bus ();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.RegWrite, bus.Illegal};

    function automatic logic [16:0] cw(input logic pcw, input logic adr, input logic mw, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] alu, input logic rw,
                                       input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
    endfunction

    task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    function automatic logic legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                             input int fw, input string tag);
        logic [16:0] q[$];
        logic [2:0] alu_tab[8] = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2};
        logic [2:0] alu_i = alu_tab[f3];
        logic [2:0] alu_r = (f3 == 3'd0 && f7) ? 3'd1 : alu_tab[f3];
        logic [16:0] aluwb = cw(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1, 0);
        for (int i = 0; i < fw; i++) q.push_back(cw(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0, 0, 0));
        q.push_back(cw(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0, 0, 0));
        q.push_back(cw(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'd0, 0, !legal(op)));
        case (op)
            7'b0000011: begin
                q.push_back(cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'd0, 0, 0));
                q.push_back(cw(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0));
                q.push_back(cw(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0, 1, 0));
            end
            7'b0100011: begin
                q.push_back(cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'd0, 0, 0));
                q.push_back(cw(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0));
            end
            7'b0110011: begin
                q.push_back(cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu_r, 0, 0));
                q.push_back(aluwb);
            end
            7'b0010011: begin
                q.push_back(cw(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu_i, 0, 0));
                q.push_back(aluwb);
            end
            7'b1100011: q.push_back(cw(z ^ f3[0], 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'd1, 0, 0));
            7'b1101111: begin
                q.push_back(cw(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'd0, 0, 0));
                q.push_back(aluwb);
            end
            default: ;
        endcase
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        bus.zero = z;
        for (int i = 0; i < q.size(); i++) begin
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
            bus.mem_ready = (i >= fw);
`else
            bus.mem_ready = 1'($urandom);
`endif
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, i), obs, q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    logic [16:0] fetch_rst;
    logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

    initial begin
        fetch_rst = cw(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0, 0, 0);
        bus.op = 7'b1111111;
        bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.zero = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_%0d", i), obs, fetch_rst);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(7'b0000011, 3'd2, 0, 0, 0, "lw");
        run_instr(7'b0100011, 3'd2, 1, 1, 0, "sw");
        run_instr(7'b0110011, 3'd0, 1, 0, 0, "sub");
        run_instr(7'b0110011, 3'd0, 0, 0, 0, "add");
        run_instr(7'b0010011, 3'd0, 1, 0, 0, "addi_f7");
        run_instr(7'b0110011, 3'd2, 0, 0, 0, "slt");
        run_instr(7'b0110011, 3'd6, 0, 0, 0, "or");
        run_instr(7'b0010011, 3'd7, 1, 0, 0, "andi");
        run_instr(7'b0010011, 3'd4, 0, 0, 0, "xori_add");
        run_instr(7'b1100011, 3'd0, 0, 1, 0, "beq_taken");
        run_instr(7'b1100011, 3'd0, 0, 0, 0, "beq_not");
        run_instr(7'b1100011, 3'd1, 0, 0, 0, "bne_taken");
        run_instr(7'b1100011, 3'd1, 0, 1, 0, "bne_not");
        run_instr(7'b1101111, 3'd3, 1, 1, 0, "jal");
        run_instr(7'b1111111, 3'd0, 0, 0, 0, "illegal");
        bus.op = 7'b0000011;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset", obs, fetch_rst);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(7'b0000011, 3'd2, 0, 0, 0, "after_reset");
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        run_instr(7'b0110011, 3'd0, 1, 0, 2, "fetch_wait");
`endif
        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            op = (n % 8 == 7) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 0, $sformatf("rnd%0d", n));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
